// File: rtl/dmem_access_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Holds the operation encoding seen on req_op, the FSM state encoding,
// the lane-width constants used when slicing memory words, and the
// default placement of the data memory in the address map.
package dmem_access_pkg;

    // Lane widths used when slicing and merging memory words
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // Default placement of the data memory in the byte address space
    localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h1000_0000;
    localparam int unsigned DMEM_BYTES_DEFAULT = 512;

    // Operation codes carried on req_op; codes above SW are undefined and fault
    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SB  = 4'd7,
        SH  = 4'd8,
        SW  = 4'd9
    } lsu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   op         - operation code (lsu_op_t encoding)
//   lane       - byte lane within the word (addr[1:0])
//   word       - word read from data memory
//   rt_old     - current rt value, merged into LWL/LWR results
//   wdata      - store data from the CPU
//   load_data  - formatted load result (sign/zero extended or LWL/LWR merged)
//   store_word - word to write back for SB/SH (addressed lanes replaced)
module dmem_lane_align
    import dmem_access_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] rt_old,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    lsu_op_t            op_e;
    logic [BYTE_W-1:0]  byte_sel;
    logic [HALF_W-1:0]  half_sel;
    logic [WORD_W-1:0]  shifted;

    assign op_e     = lsu_op_t'(op);
    assign shifted  = word >> (BYTE_W * int'(lane));
    assign byte_sel = shifted[BYTE_W-1:0];
    assign half_sel = lane[1] ? word[31:16] : word[15:0];

    // Load formatting. LWL fills the upper bytes from the low end of the
    // memory word; LWR fills the lower bytes from the high end. Bytes not
    // supplied by memory keep the old rt contents.
    always_comb begin
        load_data = word;
        case (op_e)
            LB:  load_data = {{(WORD_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
            LBU: load_data = {{(WORD_W-BYTE_W){1'b0}}, byte_sel};
            LH:  load_data = {{(WORD_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
            LHU: load_data = {{(WORD_W-HALF_W){1'b0}}, half_sel};
            LWL: begin
                case (lane)
                    2'd0:    load_data = {word[7:0],  rt_old[23:0]};
                    2'd1:    load_data = {word[15:0], rt_old[15:0]};
                    2'd2:    load_data = {word[23:0], rt_old[7:0]};
                    default: load_data = word;
                endcase
            end
            LWR: begin
                case (lane)
                    2'd0:    load_data = word;
                    2'd1:    load_data = {rt_old[31:24], word[31:8]};
                    2'd2:    load_data = {rt_old[31:16], word[31:16]};
                    default: load_data = {rt_old[31:8],  word[31:24]};
                endcase
            end
            default: load_data = word;
        endcase
    end

    // Store merge for the read-modify-write path; only the addressed
    // lane(s) take the new data, everything else is the word just read.
    always_comb begin
        store_word = wdata;
        case (op_e)
            SB: begin
                store_word = word;
                case (lane)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            SH: store_word = lane[1] ? {wdata[15:0], word[15:0]}
                                     : {word[31:16], wdata[15:0]};
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store unit between the CPU datapath and a word-wide data memory.
// Accepts one request at a time, turns byte/halfword/unaligned accesses into
// whole-word memory accesses (read-modify-write for SB/SH), formats load data
// and reports misaligned, undefined or out-of-range accesses as faults.
// Ports:
//   clk, reset_n          - clock and asynchronous active-low reset
//   req_valid/req_ready   - request handshake (ready only while idle)
//   req_op/addr/wdata/rt_old - request fields
//   resp_valid/rdata/fault   - one-cycle completion pulse and result
//   mem_address/writedata/write/readdata - word-wide data memory port
module dmem_access_unit
    import dmem_access_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT,
    parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic        mem_write,
    input  logic [31:0] mem_readdata
);

    localparam logic [31:0] DMEM_LIMIT = DMEM_BYTES;

    state_t      state, next_state;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rt_old_q;
    logic        fault_q;
    logic [31:0] rdata_q;
    logic [31:0] merge_q;

    logic [31:0] req_offset;
    logic        req_undefined;
    logic        req_misaligned;
    logic        req_out_of_range;
    logic        req_fault;
    logic        req_is_load;
    logic [31:0] word_addr;
    logic [31:0] load_data;
    logic [31:0] store_word;

    // Classify the incoming request. The range check subtracts the base from
    // the aligned address so that addresses below the base wrap to a huge
    // offset and fail the same single comparison as those above the top.
    assign req_offset       = {req_addr[31:2], 2'b00} - DMEM_BASE;
    assign req_out_of_range = req_offset >= DMEM_LIMIT;
    assign req_undefined    = req_op > 4'(SW);
    assign req_misaligned   = ((req_op == 4'(LH) || req_op == 4'(LHU) || req_op == 4'(SH)) && req_addr[0])
                            || ((req_op == 4'(LW) || req_op == 4'(SW)) && (req_addr[1:0] != 2'b00));
    assign req_fault        = req_undefined || req_misaligned || req_out_of_range;
    assign req_is_load      = req_op <= 4'(LWR);

    assign word_addr = {addr_q[31:2], 2'b00};

    dmem_lane_align u_lane_align (
        .op         (op_q),
        .lane       (addr_q[1:0]),
        .word       (mem_readdata),
        .rt_old     (rt_old_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register; reset drops any operation in flight immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request capture and the two memory samples: the formatted load result
    // at the end of LOAD and the merged store word at the end of RMW_RD.
    // rdata_q is cleared on acceptance so stores and faults respond with 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rt_old_q <= '0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
            merge_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rt_old_q <= req_rt_old;
                        fault_q  <= req_fault;
                        rdata_q  <= '0;
                    end
                end
                ST_LOAD:   rdata_q <= load_data;
                ST_RMW_RD: merge_q <= store_word;
                default: ;
            endcase
        end
    end

    // Next-state and outputs. The memory port is driven only in the states
    // that actually access memory and is zero everywhere else.
    always_comb begin
        next_state    = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_fault    = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        mem_write     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_fault)                 next_state = ST_RESP;
                    else if (req_is_load)          next_state = ST_LOAD;
                    else if (req_op == 4'(SW))     next_state = ST_WRITE;
                    else                           next_state = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                mem_address = word_addr;
                next_state  = ST_RESP;
            end
            ST_WRITE: begin
                mem_address   = word_addr;
                mem_writedata = wdata_q;
                mem_write     = 1'b1;
                next_state    = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_address = word_addr;
                next_state  = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_address   = word_addr;
                mem_writedata = merge_q;
                mem_write     = 1'b1;
                next_state    = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_fault = fault_q;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule
